// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-in / word-write bundle between UART receiver, loader and instruction memory.
// Latency: none; plain wires.
// Backpressure: none; rx_valid is a one-cycle strobe that the loader must take.
// Ports (master = loader side):
//   rx_data/rx_valid              byte stream from the UART receiver
//   wr_en/wr_addr/wr_data         instruction-memory write port
//   cpu_hold/busy/done/err        CPU hold and status
interface imem_loader_if #(
    parameter int ADDR_W = 12
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  rx_data, rx_valid,
        output wr_en, wr_addr, wr_data, cpu_hold, busy, done, err
    );

    modport slave (
        output rx_data, rx_valid,
        input  wr_en, wr_addr, wr_data, cpu_hold, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: parses a framed UART download (HEADER, addr, count, words[, csum]) into 16-bit imem writes.
// Latency: wr_en, done and err are registered, one clock after the rx_valid of the byte causing them.
// Backpressure: none; a byte can be taken every clock. Optional checksum byte: LOADER_CHECKSUM_EN.
// Ports: clk, reset (sync, active-high), bus (imem_loader_if.master: rx byte in, write port out,
//        cpu_hold/busy high while a frame is open, done/err one-clock completion pulses).
module imem_loader #(
    parameter int         ADDR_W         = 12,
    parameter logic [7:0] HEADER         = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input logic           clk,
    input logic           reset,
    imem_loader_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, DATA_H, DATA_L
`ifdef LOADER_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        hi;         // high byte of address, count or data word
    logic [ADDR_W-1:0] addr;       // next write address
    logic [15:0]       remaining;  // words still to receive
    logic [7:0]        csum;
    logic [TW-1:0]     tcnt;       // idle clocks since the last accepted byte
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [15:0]       wr_data_q;
    logic              done_q;
    logic              err_q;
    logic              do_write;
    logic              fin_ok;
    logic              fin_err;
    logic              expire;
    logic [15:0]       word;

    assign word = {hi, bus.rx_data};

    // A byte arriving on the expiry clock wins over the timeout.
    assign expire = (state != IDLE) && !bus.rx_valid && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_write  = 1'b0;
        fin_ok    = 1'b0;
        fin_err   = 1'b0;
        if (expire) begin
            state_nxt = IDLE;
            fin_err   = 1'b1;
        end else if (bus.rx_valid) begin
            case (state)
                IDLE:   if (bus.rx_data == HEADER) state_nxt = ADDR_H;
                ADDR_H: state_nxt = ADDR_L;
                ADDR_L: state_nxt = CNT_H;
                CNT_H:  state_nxt = CNT_L;
                CNT_L: begin
                    if (word == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_nxt = CSUM;
`else
                        state_nxt = IDLE;
                        fin_ok    = 1'b1;
`endif
                    end else begin
                        state_nxt = DATA_H;
                    end
                end
                DATA_H: state_nxt = DATA_L;
                DATA_L: begin
                    do_write = 1'b1;
                    if (remaining == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                        state_nxt = CSUM;
`else
                        state_nxt = IDLE;
                        fin_ok    = 1'b1;
`endif
                    end else begin
                        state_nxt = DATA_H;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: begin
                    state_nxt = IDLE;
                    if (bus.rx_data == csum) fin_ok  = 1'b1;
                    else                     fin_err = 1'b1;
                end
`endif
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi        <= '0;
            addr      <= '0;
            remaining <= '0;
            csum      <= '0;
            tcnt      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= do_write;
            done_q  <= fin_ok;
            err_q   <= fin_err;

            if (state_nxt == IDLE || bus.rx_valid) tcnt <= '0;
            else                                   tcnt <= tcnt + TW'(1);

            if (bus.rx_valid) begin
                case (state)
                    IDLE:   if (bus.rx_data == HEADER) csum <= '0;
                    ADDR_H: hi <= bus.rx_data;
                    ADDR_L: addr <= word[ADDR_W-1:0];
                    CNT_H:  hi <= bus.rx_data;
                    CNT_L:  remaining <= word;
                    DATA_H: begin
                        hi   <= bus.rx_data;
                        csum <= csum ^ bus.rx_data;
                    end
                    DATA_L: begin
                        wr_addr_q <= addr;
                        wr_data_q <= word;
                        addr      <= addr + ADDR_W'(1);
                        remaining <= remaining - 16'd1;
                        csum      <= csum ^ bus.rx_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.cpu_hold = (state != IDLE);
    assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives framed downloads into imem_loader and checks writes, hold and status pulses.
// Latency: expects outputs one clock after the causing byte strobe.
// Backpressure: none; bytes are sent with random gaps including back-to-back.
module tb_imem_loader;
    localparam int AW = 12;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    imem_loader_if #(.ADDR_W(AW)) bus ();

    imem_loader #(.ADDR_W(AW), .HEADER(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Observed activity log, written only here.
    logic [AW+15:0] wq[$];
    int done_cnt = 0;
    int err_cnt = 0;
    int hold_bad = 0;
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) wq.push_back({bus.wr_addr, bus.wr_data});
        if (bus.done === 1'b1) done_cnt++;
        if (bus.err === 1'b1) err_cnt++;
        if (bus.cpu_hold !== bus.busy) hold_bad++;
    end

    int wbase, dbase, ebase;
    task automatic mark();
        wbase = wq.size();
        dbase = done_cnt;
        ebase = err_cnt;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    function automatic int rg(input int maxgap);
        return int'($urandom_range(maxgap, 0));
    endfunction

    // Sends one frame and checks it against the frame rules: word i lands at (start+i) mod 2^AW,
    // checksum is the XOR of payload bytes; csum_flip corrupts the checksum byte sent.
    task automatic run_frame(input logic [15:0] start, input int n, input logic [15:0] w[8],
                             input logic [7:0] csum_flip, input int maxgap);
        logic [7:0]     cs;
        logic [15:0]    cnt;
        logic [AW-1:0]  ea;
        logic [AW+15:0] exp_e;
        bit             ok;
        cs  = 8'h00;
        cnt = 16'(n);
        ok  = (csum_flip == 8'h00);
        send_byte(8'hA5, rg(maxgap));
        checks++;
        if (bus.cpu_hold !== 1'b1) begin
            failures++; $display("FAIL hold_rise got=%b exp=1", bus.cpu_hold);
        end
        send_byte(start[15:8], rg(maxgap));
        send_byte(start[7:0], rg(maxgap));
        send_byte(cnt[15:8], rg(maxgap));
        send_byte(cnt[7:0], rg(maxgap));
        for (int i = 0; i < n; i++) begin
            ea = AW'((int'(start) + i) % (1 << AW));
            cs = cs ^ w[i][15:8] ^ w[i][7:0];
            send_byte(w[i][15:8], rg(maxgap));
            send_byte(w[i][7:0], rg(maxgap));
            checks++;
            if (bus.wr_en !== 1'b1 || bus.wr_addr !== ea || bus.wr_data !== w[i]) begin
                failures++;
                $display("FAIL write_now[%0d] got=%b/%h/%h exp=1/%h/%h", i,
                         bus.wr_en, bus.wr_addr, bus.wr_data, ea, w[i]);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(cs ^ csum_flip, rg(maxgap));
`endif
        checks++;
        if (bus.done !== ok || bus.err !== !ok || bus.cpu_hold !== 1'b0) begin
            failures++;
            $display("FAIL frame_end got done=%b err=%b hold=%b exp done=%b err=%b hold=0",
                     bus.done, bus.err, bus.cpu_hold, ok, !ok);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wq.size() - wbase != n) begin
            failures++; $display("FAIL write_count got=%0d exp=%0d", wq.size() - wbase, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_e = {AW'((int'(start) + i) % (1 << AW)), w[i]};
                checks++;
                if (wq[wbase + i] !== exp_e) begin
                    failures++; $display("FAIL write_log[%0d] got=%h exp=%h", i, wq[wbase + i], exp_e);
                end
            end
        end
        checks++;
        if (done_cnt - dbase != int'(ok) || err_cnt - ebase != int'(!ok)) begin
            failures++;
            $display("FAIL pulse_count got done=%0d err=%0d exp done=%0d err=%0d",
                     done_cnt - dbase, err_cnt - ebase, int'(ok), int'(!ok));
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.cpu_hold, bus.busy, bus.done, bus.err} !== '0) begin
            failures++;
            $display("FAIL %s got en=%b addr=%h data=%h hold=%b busy=%b done=%b err=%b exp all zero",
                     name, bus.wr_en, bus.wr_addr, bus.wr_data, bus.cpu_hold, bus.busy, bus.done, bus.err);
        end
    endtask

    task automatic test_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_state");
    endtask

    task automatic test_basic();
        logic [15:0] wd[8];
        wd = '{default: 16'h0};
        wd[0] = 16'h0D00; wd[1] = 16'h0D41;
        mark();
        run_frame(16'h0064, 2, wd, 8'h00, 0);
        mark();
        run_frame(16'h0064, 2, wd, 8'h00, 2);
    endtask

    task automatic test_garbage();
        logic [7:0]  g[3];
        logic [15:0] wd[8];
        g = '{8'h00, 8'hFF, 8'h3C};
        wd = '{default: 16'h0};
        wd[0] = 16'h1D04;
        mark();
        for (int i = 0; i < 3; i++) begin
            send_byte(g[i], i);
            checks++;
            if (bus.cpu_hold !== 1'b0) begin
                failures++; $display("FAIL garbage_hold[%0d] got=%b exp=0", i, bus.cpu_hold);
            end
        end
        run_frame(16'd200, 1, wd, 8'h00, 1);
    endtask

    task automatic test_wrap();
        logic [15:0] wd[8];
        wd = '{default: 16'h0};
        wd[0] = 16'h1111; wd[1] = 16'h2222;
        mark();
        run_frame(16'h0FFF, 2, wd, 8'h00, 0);
        // Upper address bits are discarded.
        wd[2] = 16'hA5A5;
        mark();
        run_frame(16'hFFFE, 3, wd, 8'h00, 1);
    endtask

    task automatic test_zero_count();
        logic [15:0] wd[8];
        wd = '{default: 16'h0};
        mark();
        run_frame(16'h0123, 0, wd, 8'h00, 0);
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        logic [15:0] wd[8];
        wd = '{default: 16'h0};
        wd[0] = 16'h0D00; wd[1] = 16'h0D41;
        mark();
        run_frame(16'h0064, 2, wd, 8'h41, 0);
    endtask
`endif

    task automatic test_timeout();
        int          seen;
        logic [15:0] wd[8];
        mark();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        // Arrives on the clock the counter would expire: must be accepted.
        send_byte(8'h12, TO - 1);
        checks++;
        if (bus.err !== 1'b0 || bus.cpu_hold !== 1'b1) begin
            failures++; $display("FAIL timeout_edge got err=%b hold=%b exp err=0 hold=1", bus.err, bus.cpu_hold);
        end
        seen = 0;
        for (int i = 1; i <= 40 && seen == 0; i++) begin
            @(negedge clk);
            if (bus.err === 1'b1) seen = i;
        end
        checks++;
        if (seen != TO || bus.cpu_hold !== 1'b0) begin
            failures++; $display("FAIL timeout_abort got clocks=%0d hold=%b exp clocks=%0d hold=0", seen, bus.cpu_hold, TO);
        end
        send_byte(8'h34, 2);  // late low byte must not write
        repeat (3) @(negedge clk);
        checks++;
        if (wq.size() != wbase || err_cnt - ebase != 1 || done_cnt != dbase) begin
            failures++;
            $display("FAIL timeout_effects got writes=%0d err=%0d done=%0d exp 0/1/0",
                     wq.size() - wbase, err_cnt - ebase, done_cnt - dbase);
        end
        wd = '{default: 16'h0};
        wd[0] = 16'hBEEF; wd[1] = 16'h0042;
        mark();
        run_frame(16'h0300, 2, wd, 8'h00, 1);
    endtask

    task automatic test_reset_mid();
        mark();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h33, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("reset_mid_outputs");
        send_byte(8'h44, 0);
        checks++;
        if (bus.wr_en !== 1'b0) begin
            failures++; $display("FAIL reset_mid_write got=%b exp=0", bus.wr_en);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wq.size() != wbase || done_cnt != dbase || err_cnt != ebase) begin
            failures++;
            $display("FAIL reset_mid_effects got writes=%0d done=%0d err=%0d exp 0/0/0",
                     wq.size() - wbase, done_cnt - dbase, err_cnt - ebase);
        end
    endtask

    task automatic test_random();
        logic [15:0] wd[8];
        logic [15:0] start;
        int          n;
        for (int f = 0; f < 8; f++) begin
            wd = '{default: 16'h0};
            n = int'($urandom_range(6, 1));
            start = 16'($urandom);
            for (int i = 0; i < n; i++) wd[i] = 16'($urandom);
            mark();
            run_frame(start, n, wd, 8'h00, (f % 2 == 0) ? 0 : 3);
        end
    endtask

    task automatic test_hold_tracks_busy();
        checks++;
        if (hold_bad != 0) begin
            failures++; $display("FAIL busy_vs_hold got mismatched_clocks=%0d exp=0", hold_bad);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_garbage();
        test_wrap();
        test_zero_count();
`ifdef LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_timeout();
        test_reset_mid();
        test_random();
        test_hold_tracks_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
